mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
- Multi-cycle sequencing FSM for the MIPS core.
- Replaces single-cycle opcode decode with a Moore state machine that steps one shared ALU/memory datapath through fetch, decode, execute, memory and writeback.
- Sits between the instruction register (op, funct fields) and the datapath muxes and enables.
- Stalls on a memory ready handshake.

Parameters:
- JR_FUNCT, 6'b001000, funct code identifying jr within R-type.
- CNT_W, 32, width of the performance counters; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- op  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory has completed the current read or write this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if zero
- i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load
- mem_to_reg  out  2  write data: 00 = ALUOut, 01 = MDR, 10 = PC
- reg_dst  out  2  destination: 00 = rt, 01 = rd, 10 = $31
- reg_write  out  1  register file write
- alu_src_a  out  1  0 = PC, 1 = A
- alu_src_b  out  2  00 = B, 01 = 4, 10 = ext imm, 11 = ext imm<<2
- alu_op  out  3  000 = R (funct), 001 = add, 010 = addi, 011 = andi (zero-ext), 110 = sub/beq
- pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = A (jr)
- state_o  out  4  current state, for debug
- illegal_op  out  1  one-cycle pulse on an unknown opcode

Behaviour:
- Structure: 4-bit state register updated on posedge clk. All outputs are combinational Moore decodes of state, except the mem_ready/zero gating described below. Any output not listed for a state is 0.
- Reset: while rst = 1, all outputs are forced to 0 and state_o = FETCH. The next state after reset is FETCH. Reset mid-instruction abandons the instruction; partial writes already committed stay committed.
- FETCH: mem_read = 1, alu_src_b = 01, alu_op = 001.
  - ir_write and pc_write assert only in a cycle where mem_ready = 1.
  - Stays in FETCH while mem_ready = 0; moves to DECODE when mem_ready = 1.
- DECODE: alu_src_b = 11, alu_op = 001 (computes branch target).
  - lw/sw -> MEMADR; R-type with funct == JR_FUNCT -> JR; other R-type -> EXEC.
  - beq -> BRANCH; addi/andi -> IEXEC; j -> JUMP; jal -> JAL.
  - Any other opcode -> FETCH with illegal_op = 1 for that cycle.
- MEMADR: alu_src_a = 1, alu_src_b = 10, alu_op = 001. lw -> MEMRD; sw -> MEMWR.
- MEMRD: mem_read = 1, i_or_d = 1. Waits for mem_ready, then -> MEMWB.
- MEMWB: reg_write = 1, mem_to_reg = 01, reg_dst = 00. Then -> FETCH.
- MEMWR: mem_write = 1, i_or_d = 1. Waits for mem_ready, then -> FETCH.
- EXEC: alu_src_a = 1, alu_src_b = 00, alu_op = 000. Then -> ALUWB.
- ALUWB: reg_write = 1, reg_dst = 01, mem_to_reg = 00. Then -> FETCH.
- IEXEC: alu_src_a = 1, alu_src_b = 10, alu_op = 010 (addi) or 011 (andi). Then -> IWB.
- IWB: reg_write = 1, reg_dst = 00. Then -> FETCH.
  - op is held stable by the IR across IEXEC.
- BRANCH: alu_src_a = 1, alu_op = 110, pc_write_cond = 1, pc_src = 01. Then -> FETCH.
- JUMP: pc_write = 1, pc_src = 10. Then -> FETCH.
- JR: pc_write = 1, pc_src = 11. Then -> FETCH.
- JAL: reg_write = 1, reg_dst = 10, mem_to_reg = 10, pc_write = 1, pc_src = 10. Then -> FETCH.
  - Register write and PC update happen on the same edge; the datapath samples the old PC (already PC+4).
- Cycles per instruction with mem_ready held at 1:
  - lw: 5
  - sw, R-type, addi, andi: 4
  - beq, j, jr, jal: 3
  - Every mem_ready = 0 cycle in FETCH, MEMRD or MEMWR adds exactly 1.
- mem_read and mem_write are never both 1. mem_write is asserted only in MEMWR.
- Unused state encodings -> FETCH.

Optional Feature:
- Macro: MIPS_CTRL_PERF_EN.
- When defined:
  - Adds outputs cycle_cnt[CNT_W-1:0] and instr_cnt[CNT_W-1:0].
  - cycle_cnt increments every non-reset cycle.
  - instr_cnt increments on every transition into FETCH from a non-FETCH state, excluding illegal-op returns.
  - Both counters clear on rst and wrap modulo 2^CNT_W.
- When undefined: the ports and logic are absent.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state encodings: FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5, EXEC = 6, ALUWB = 7, BRANCH = 8, IEXEC = 9, IWB = 10, JUMP = 11, JR = 12, JAL = 13
  - opcode constants: RTYPE 000000, LW 100011, SW 101011, ANDI 001100, ADDI 001000, BEQ 000100, J 000010, JAL 000011
  - alu_op, pc_src, alu_src_b, mem_to_reg and reg_dst encodings
- One sub-module, mips_ctrl_outdec: a purely combinational state/op -> control-word decode. The top module keeps the state register and next-state logic.

Test Plan:
- lw (op 100011), mem_ready = 1 -> state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH. reg_write = 1 and mem_to_reg = 01 only in MEMWB; 5 cycles.
- sw with mem_ready held 0 for 3 cycles in MEMWR -> mem_write = 1 for 4 cycles, reg_write never 1, then FETCH.
- R-type funct 100000 -> EXEC then ALUWB with reg_dst = 01. Same op with funct 001000 -> JR with pc_src = 11 and pc_write = 1, no register write.
- beq with zero = 1 and zero = 0 -> pc_write_cond = 1 in BRANCH in both cases, pc_src = 01, 3 cycles; pc_write stays 0.
- jal -> JAL state with reg_dst = 10, mem_to_reg = 10, reg_write = 1, pc_src = 10. Op 111111 -> illegal_op pulses 1 cycle, state returns to FETCH.
- rst = 1 asserted in MEMRD -> all outputs 0 during reset, state FETCH afterwards. FETCH with mem_ready = 0 for 2 cycles -> no ir_write or pc_write until mem_ready = 1.

Source files
------------

// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: states, opcodes, mux selects.
// The control word struct is the contract between the FSM top and the output decoder.
package mips_ctrl_pkg;

  localparam logic [3:0] ST_FETCH  = 4'd0;
  localparam logic [3:0] ST_DECODE = 4'd1;
  localparam logic [3:0] ST_MEMADR = 4'd2;
  localparam logic [3:0] ST_MEMRD  = 4'd3;
  localparam logic [3:0] ST_MEMWB  = 4'd4;
  localparam logic [3:0] ST_MEMWR  = 4'd5;
  localparam logic [3:0] ST_EXEC   = 4'd6;
  localparam logic [3:0] ST_ALUWB  = 4'd7;
  localparam logic [3:0] ST_BRANCH = 4'd8;
  localparam logic [3:0] ST_IEXEC  = 4'd9;
  localparam logic [3:0] ST_IWB    = 4'd10;
  localparam logic [3:0] ST_JUMP   = 4'd11;
  localparam logic [3:0] ST_JR     = 4'd12;
  localparam logic [3:0] ST_JAL    = 4'd13;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [2:0] ALU_FUNCT = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_ADDI  = 3'b010;
  localparam logic [2:0] ALU_ANDI  = 3'b011;
  localparam logic [2:0] ALU_SUB   = 3'b110;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_A      = 2'b11;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_4      = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] mem_to_reg;
    logic [1:0] reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic       illegal_op;
  } ctrl_word_t;

  function automatic logic is_known_op(input logic [5:0] op);
    logic known;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_ANDI, OP_ADDI, OP_BEQ, OP_J, OP_JAL: known = 1'b1;
      default: known = 1'b0;
    endcase
    return known;
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath bundle: IR fields and flags in, mux selects and enables out.
// master = controller side, slave = datapath side.
interface mips_multicycle_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] mem_to_reg;
  logic [1:0] reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic [1:0] pc_src;
  logic [3:0] state_o;
  logic       illegal_op;

  modport master (
    input  op, funct, zero, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_src, state_o, illegal_op
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_src, state_o, illegal_op
  );
endinterface

// File: rtl/mips_multicycle_ctrl_outdec.sv
// Purely combinational Moore decode of FSM state (plus op / mem_ready where the
// state needs them) into the datapath control word.
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  logic [3:0] state_i,
  input  logic [5:0] op_i,
  input  logic       mem_ready_i,
  output ctrl_word_t ctrl_o
);

  // state -> control word, everything unlisted stays 0
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      ST_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_4;
        ctrl_o.alu_op    = ALU_ADD;
        // IR and PC+4 commit only on the cycle the fetch completes
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      ST_DECODE: begin
        ctrl_o.alu_src_b  = SRCB_IMM_SH;
        ctrl_o.alu_op     = ALU_ADD;
        ctrl_o.illegal_op = ~is_known_op(op_i);
      end
      ST_MEMADR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALU_ADD;
      end
      ST_MEMRD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
      end
      ST_MEMWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = M2R_MDR;
        ctrl_o.reg_dst    = RD_RT;
      end
      ST_MEMWR: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.i_or_d    = 1'b1;
      end
      ST_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_B;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      ST_ALUWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = RD_RD;
        ctrl_o.mem_to_reg = M2R_ALUOUT;
      end
      ST_IEXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = (op_i == OP_ANDI) ? ALU_ANDI : ALU_ADDI;
      end
      ST_IWB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = RD_RT;
      end
      ST_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_op        = ALU_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_src        = PC_ALUOUT;
      end
      ST_JUMP: begin
        ctrl_o.pc_write = 1'b1;
        ctrl_o.pc_src   = PC_JUMP;
      end
      ST_JR: begin
        ctrl_o.pc_write = 1'b1;
        ctrl_o.pc_src   = PC_A;
      end
      ST_JAL: begin
        // link captures the already-incremented PC on the same edge as the jump
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = RD_RA;
        ctrl_o.mem_to_reg = M2R_PC;
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.pc_src     = PC_JUMP;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS sequencing FSM: state register, next-state logic, reset gating.
// Define MIPS_CTRL_PERF_EN to add cycle_cnt / instr_cnt performance counters.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter logic [5:0] JR_FUNCT = 6'b001000,
  parameter int         CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  mips_multicycle_ctrl_if.master bus
`ifdef MIPS_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]    cycle_cnt,
  output logic [CNT_W-1:0]    instr_cnt
`endif
);

  logic [3:0] state_q;
  logic [3:0] state_d;
  ctrl_word_t ctrl_s;
  ctrl_word_t ctrl_out_s;
  logic       unused_s;

  // zero is consumed by the datapath via pc_write_cond, not by the sequencer
  assign unused_s = bus.zero ^ CNT_W[0];

  // next-state selection
  always_comb begin
    state_d = ST_FETCH;
    case (state_q)
      ST_FETCH:  state_d = bus.mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (bus.op)
          OP_RTYPE:     state_d = (bus.funct == JR_FUNCT) ? ST_JR : ST_EXEC;
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_ADDI,
          OP_ANDI:      state_d = ST_IEXEC;
          OP_J:         state_d = ST_JUMP;
          OP_JAL:       state_d = ST_JAL;
          default:      state_d = ST_FETCH;
        endcase
      end
      ST_MEMADR: state_d = (bus.op == OP_LW) ? ST_MEMRD : ST_MEMWR;
      ST_MEMRD:  state_d = bus.mem_ready ? ST_MEMWB : ST_MEMRD;
      ST_MEMWR:  state_d = bus.mem_ready ? ST_FETCH : ST_MEMWR;
      ST_EXEC:   state_d = ST_ALUWB;
      ST_IEXEC:  state_d = ST_IWB;
      ST_MEMWB, ST_ALUWB, ST_IWB, ST_BRANCH,
      ST_JUMP, ST_JR, ST_JAL: state_d = ST_FETCH;
      default:   state_d = ST_FETCH;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  mips_ctrl_outdec u_outdec (
    .state_i     (state_q),
    .op_i        (bus.op),
    .mem_ready_i (bus.mem_ready),
    .ctrl_o      (ctrl_s)
  );

  // reset silences every enable so an abandoned instruction commits nothing more
  assign ctrl_out_s = rst ? ctrl_word_t'('0) : ctrl_s;

  assign bus.pc_write      = ctrl_out_s.pc_write;
  assign bus.pc_write_cond = ctrl_out_s.pc_write_cond;
  assign bus.i_or_d        = ctrl_out_s.i_or_d;
  assign bus.mem_read      = ctrl_out_s.mem_read;
  assign bus.mem_write     = ctrl_out_s.mem_write;
  assign bus.ir_write      = ctrl_out_s.ir_write;
  assign bus.mem_to_reg    = ctrl_out_s.mem_to_reg;
  assign bus.reg_dst       = ctrl_out_s.reg_dst;
  assign bus.reg_write     = ctrl_out_s.reg_write;
  assign bus.alu_src_a     = ctrl_out_s.alu_src_a;
  assign bus.alu_src_b     = ctrl_out_s.alu_src_b;
  assign bus.alu_op        = ctrl_out_s.alu_op;
  assign bus.pc_src        = ctrl_out_s.pc_src;
  assign bus.illegal_op    = ctrl_out_s.illegal_op;
  assign bus.state_o       = rst ? ST_FETCH : state_q;

`ifdef MIPS_CTRL_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cycle_cnt_q;
  logic [CNT_W-1:0] instr_cnt_q;
  logic             retire_s;

  // an instruction retires when the FSM returns to FETCH, illegal-op bounces excluded
  assign retire_s = (state_q != ST_FETCH) && (state_d == ST_FETCH) && !ctrl_s.illegal_op;

  // free-running cycle and retired-instruction counters
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_q + CNT_ONE;
      instr_cnt_q <= retire_s ? (instr_cnt_q + CNT_ONE) : instr_cnt_q;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: table of instruction state walks
// plus hand-written stall/reset sequences, checked through an expectation queue.
module tb_mips_multicycle_ctrl;

  localparam logic [3:0] S_F   = 4'd0,  S_D   = 4'd1,  S_MA  = 4'd2,  S_MR  = 4'd3;
  localparam logic [3:0] S_MWB = 4'd4,  S_MW  = 4'd5,  S_EX  = 4'd6,  S_AWB = 4'd7;
  localparam logic [3:0] S_BR  = 4'd8,  S_IE  = 4'd9,  S_IWB = 4'd10, S_J   = 4'd11;
  localparam logic [3:0] S_JR  = 4'd12, S_JAL = 4'd13;

  localparam logic [5:0] O_R = 6'b000000, O_LW = 6'b100011, O_SW = 6'b101011;
  localparam logic [5:0] O_ANDI = 6'b001100, O_ADDI = 6'b001000, O_BEQ = 6'b000100;
  localparam logic [5:0] O_J = 6'b000010, O_JAL = 6'b000011, O_BAD = 6'b111111;

  typedef struct {
    string       tag;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    int          len;
    logic [23:0] seq;   // nibble k = expected state in cycle k
  } vec_t;

  typedef struct {
    string       tag;
    logic [3:0]  state;
    logic [19:0] word;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sbq[$];
  exp_t mon_e;
  vec_t vecs[11];

  mips_multicycle_ctrl_if bus ();

`ifdef MIPS_CTRL_PERF_EN
  logic [31:0] cycle_cnt;
  logic [31:0] instr_cnt;
`endif

  mips_multicycle_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef MIPS_CTRL_PERF_EN
    ,
    .cycle_cnt (cycle_cnt),
    .instr_cnt (instr_cnt)
`endif
  );

  always #5 clk = ~clk;

  // reference control word straight from the state table
  function automatic logic [19:0] exp_word(input logic [3:0] st, input logic [5:0] op, input logic mr);
    logic pcw, pcwc, iord, mrd, mwr, irw, rw, asa, ill;
    logic [1:0] m2r, rdst, asb, pcs;
    logic [2:0] aop;
    {pcw, pcwc, iord, mrd, mwr, irw, rw, asa, ill} = 9'b0;
    {m2r, rdst, asb, pcs} = 8'b0;
    aop = 3'b000;
    case (st)
      S_F:   begin mrd = 1'b1; asb = 2'b01; aop = 3'b001; irw = mr; pcw = mr; end
      S_D:   begin asb = 2'b11; aop = 3'b001;
                   ill = !(op inside {O_R, O_LW, O_SW, O_ANDI, O_ADDI, O_BEQ, O_J, O_JAL}); end
      S_MA:  begin asa = 1'b1; asb = 2'b10; aop = 3'b001; end
      S_MR:  begin mrd = 1'b1; iord = 1'b1; end
      S_MWB: begin rw = 1'b1; m2r = 2'b01; end
      S_MW:  begin mwr = 1'b1; iord = 1'b1; end
      S_EX:  begin asa = 1'b1; aop = 3'b000; end
      S_AWB: begin rw = 1'b1; rdst = 2'b01; end
      S_IE:  begin asa = 1'b1; asb = 2'b10; aop = (op == O_ANDI) ? 3'b011 : 3'b010; end
      S_IWB: begin rw = 1'b1; end
      S_BR:  begin asa = 1'b1; aop = 3'b110; pcwc = 1'b1; pcs = 2'b01; end
      S_J:   begin pcw = 1'b1; pcs = 2'b10; end
      S_JR:  begin pcw = 1'b1; pcs = 2'b11; end
      S_JAL: begin rw = 1'b1; rdst = 2'b10; m2r = 2'b10; pcw = 1'b1; pcs = 2'b10; end
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, pcs, ill};
  endfunction

  // drive one cycle of stimulus and queue what the DUT must show in it
  task automatic step(input string tag, input logic r, input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input logic mr, input logic [3:0] est);
    exp_t e;
    rst = r;
    bus.op = op;
    bus.funct = fn;
    bus.zero = z;
    bus.mem_ready = mr;
    e.tag   = tag;
    e.state = r ? S_F : est;
    e.word  = r ? 20'd0 : exp_word(est, op, mr);
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // mid-cycle monitor: pop one expectation and compare against the DUT
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      n_checks++;
      if (bus.state_o === mon_e.state) n_pass++;
      else $display("FAIL %s state: got %0d want %0d", mon_e.tag, bus.state_o, mon_e.state);
      n_checks++;
      if ({bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read, bus.mem_write, bus.ir_write,
           bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
           bus.pc_src, bus.illegal_op} === mon_e.word) n_pass++;
      else $display("FAIL %s ctrl (state %0d): got %b want %b", mon_e.tag, mon_e.state,
                    {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read, bus.mem_write,
                     bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
                     bus.alu_src_b, bus.alu_op, bus.pc_src, bus.illegal_op}, mon_e.word);
    end
  end

  initial begin
    vecs[0]  = '{"lw",     O_LW,     6'b000000, 1'b0, 5, {4'd0, S_MWB, S_MR, S_MA, S_D, S_F}};
    vecs[1]  = '{"sw",     O_SW,     6'b000000, 1'b0, 4, {8'd0, S_MW, S_MA, S_D, S_F}};
    vecs[2]  = '{"add",    O_R,      6'b100000, 1'b0, 4, {8'd0, S_AWB, S_EX, S_D, S_F}};
    vecs[3]  = '{"jr",     O_R,      6'b001000, 1'b0, 3, {12'd0, S_JR, S_D, S_F}};
    vecs[4]  = '{"beq_z1", O_BEQ,    6'b000000, 1'b1, 3, {12'd0, S_BR, S_D, S_F}};
    vecs[5]  = '{"beq_z0", O_BEQ,    6'b000000, 1'b0, 3, {12'd0, S_BR, S_D, S_F}};
    vecs[6]  = '{"addi",   O_ADDI,   6'b000000, 1'b0, 4, {8'd0, S_IWB, S_IE, S_D, S_F}};
    vecs[7]  = '{"andi",   O_ANDI,   6'b000000, 1'b0, 4, {8'd0, S_IWB, S_IE, S_D, S_F}};
    vecs[8]  = '{"j",      O_J,      6'b000000, 1'b0, 3, {12'd0, S_J, S_D, S_F}};
    vecs[9]  = '{"jal",    O_JAL,    6'b000000, 1'b0, 3, {12'd0, S_JAL, S_D, S_F}};
    vecs[10] = '{"illegal", O_BAD,   6'b000000, 1'b0, 2, {16'd0, S_D, S_F}};

    rst = 1'b1;
    bus.op = 6'd0; bus.funct = 6'd0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    step("reset", 1'b1, O_LW, 6'd0, 1'b0, 1'b1, S_F);
    step("reset", 1'b1, O_LW, 6'd0, 1'b0, 1'b1, S_F);

    // each vector ends one cycle before FETCH, which the next vector's first step checks
    for (int i = 0; i < 11; i++) begin
      for (int k = 0; k < vecs[i].len; k++) begin
        step(vecs[i].tag, 1'b0, vecs[i].op, vecs[i].funct, vecs[i].zero, 1'b1, vecs[i].seq[4*k +: 4]);
      end
    end

    // sw with three waiting cycles in MEMWR
    step("sw_stall", 1'b0, O_SW, 6'd0, 1'b0, 1'b1, S_F);
    step("sw_stall", 1'b0, O_SW, 6'd0, 1'b0, 1'b1, S_D);
    step("sw_stall", 1'b0, O_SW, 6'd0, 1'b0, 1'b1, S_MA);
    step("sw_stall", 1'b0, O_SW, 6'd0, 1'b0, 1'b0, S_MW);
    step("sw_stall", 1'b0, O_SW, 6'd0, 1'b0, 1'b0, S_MW);
    step("sw_stall", 1'b0, O_SW, 6'd0, 1'b0, 1'b0, S_MW);
    step("sw_stall", 1'b0, O_SW, 6'd0, 1'b0, 1'b1, S_MW);

    // fetch stalled two cycles, then j
    step("fetch_stall", 1'b0, O_J, 6'd0, 1'b0, 1'b0, S_F);
    step("fetch_stall", 1'b0, O_J, 6'd0, 1'b0, 1'b0, S_F);
    step("fetch_stall", 1'b0, O_J, 6'd0, 1'b0, 1'b1, S_F);
    step("fetch_stall", 1'b0, O_J, 6'd0, 1'b0, 1'b1, S_D);
    step("fetch_stall", 1'b0, O_J, 6'd0, 1'b0, 1'b1, S_J);

    // lw with one wait in MEMRD
    step("lw_stall", 1'b0, O_LW, 6'd0, 1'b0, 1'b1, S_F);
    step("lw_stall", 1'b0, O_LW, 6'd0, 1'b0, 1'b1, S_D);
    step("lw_stall", 1'b0, O_LW, 6'd0, 1'b0, 1'b1, S_MA);
    step("lw_stall", 1'b0, O_LW, 6'd0, 1'b0, 1'b0, S_MR);
    step("lw_stall", 1'b0, O_LW, 6'd0, 1'b0, 1'b1, S_MR);
    step("lw_stall", 1'b0, O_LW, 6'd0, 1'b0, 1'b1, S_MWB);

    // reset arriving while a load waits in MEMRD
    step("rst_memrd", 1'b0, O_LW, 6'd0, 1'b0, 1'b1, S_F);
    step("rst_memrd", 1'b0, O_LW, 6'd0, 1'b0, 1'b1, S_D);
    step("rst_memrd", 1'b0, O_LW, 6'd0, 1'b0, 1'b1, S_MA);
    step("rst_memrd", 1'b0, O_LW, 6'd0, 1'b0, 1'b0, S_MR);
    step("rst_memrd", 1'b1, O_LW, 6'd0, 1'b0, 1'b1, S_F);
    step("rst_memrd", 1'b1, O_LW, 6'd0, 1'b0, 1'b1, S_F);
    step("rst_memrd", 1'b0, O_ADDI, 6'd0, 1'b0, 1'b1, S_F);
    step("rst_memrd", 1'b0, O_ADDI, 6'd0, 1'b0, 1'b1, S_D);

    n_checks++;
    if (sbq.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending want 0", sbq.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
